// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - instruction-cycle controller (fetch/decode/execute/writeback) for register_block
// Drives step phase, register strobes and the memory request handshake with a stall timeout.
module step_sequencer #(
  parameter int WAIT_LIMIT = 255,
  parameter int CW         = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        resume,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  input  logic [15:0] flags,
  output logic [1:0]  step,
  output logic [3:0]  desired_source,
  output logic [3:0]  desired_destination,
  output logic        write_enable,
  output logic        inc_enable,
  output logic        push,
  output logic        pop,
  output logic        write_flags,
  output logic        mem_req,
  output logic        mem_write,
  output logic        halted,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [15:0]     instr;
  logic [CW-1:0]   stall_cnt;
  logic [CW-1:0]   stall_cnt_next;
  logic            requesting;
  logic            stalling;
  logic            timeout;
  logic            src_mem;
  logic            dst_mem;
  logic            we_c;
  logic            inc_c;
  logic            push_c;
  logic            pop_c;
  logic            wf_c;
  logic            mem_write_c;
  logic            unused_flags;

  // r1-r3 and banked rb1-rb3: bit2 clear, low two bits nonzero
  function automatic logic is_mem_operand(input logic [3:0] code);
    return !code[2] && (code[1:0] != 2'b00);
  endfunction

  assign src_mem             = is_mem_operand(instr[3:0]);
  assign dst_mem             = is_mem_operand(instr[7:4]);
  assign desired_source      = instr[3:0];
  assign desired_destination = instr[7:4];
  assign unused_flags        = ^flags;

  always_comb begin
    state_next  = state;
    step        = 2'd0;
    requesting  = 1'b0;
    mem_write_c = 1'b0;
    we_c        = 1'b0;
    inc_c       = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    wf_c        = 1'b0;
    timeout     = 1'b0;
    case (state)
      S_FETCH: begin
        step       = 2'd0;
        requesting = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        step       = 2'd1;
        state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        step       = 2'd2;
        requesting = src_mem;
        if (!src_mem || mem_ready) begin
          pop_c      = instr[10];
          state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        step        = 2'd3;
        requesting  = dst_mem;
        mem_write_c = dst_mem;
        if (!dst_mem || mem_ready) begin
          we_c       = (instr[7:4] != 4'h4) && (instr[15:12] != 4'hF);
          push_c     = we_c && instr[9];
          inc_c      = instr[8];
          wf_c       = instr[11];
          state_next = (instr[15:12] == 4'hF) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        step = 2'd3;
        if (resume && !bus_error) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    stalling = requesting && !mem_ready;
    // the WAIT_LIMIT-th consecutive stalled cycle is the one that times out
    if (stalling && (stall_cnt >= CW'(WAIT_LIMIT - 1))) begin
      timeout    = 1'b1;
      state_next = S_HALT;
    end

    if (state_next != state) begin
      stall_cnt_next = '0;
    end else if (stalling && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt_next = stall_cnt + 1'b1;
    end else begin
      stall_cnt_next = stall_cnt;
    end
  end

  // reset held low silences the bus and every strobe regardless of state
  assign mem_req      = requesting  && reset;
  assign mem_write    = mem_write_c && reset;
  assign write_enable = we_c        && reset;
  assign inc_enable   = inc_c       && reset;
  assign push         = push_c      && reset;
  assign pop          = pop_c       && reset;
  assign write_flags  = wf_c        && reset;
  assign halted       = (state == S_HALT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_FETCH;
      instr     <= 16'h0000;
      stall_cnt <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      if (timeout) bus_error <= 1'b1;
      if ((state == S_FETCH) && mem_ready) instr <= mem_data;
    end
  end

endmodule
